muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It replaces the divide-only helper, which had a fixed 32-bit width, and the separate multiplier. It executes MULT/MULTU/DIV/DIVU at one bit per cycle using a start/busy/ready handshake, and returns a {hi,lo} pair for the HI/LO write path. It adds an annul mode (for flushes), divide-by-zero detection and a width parameter.

---
 rtl/muldiv_iter.sv | 123 ++++++++++++
 tb/tb_muldiv_iter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage: one bit per cycle,
// start/busy/ready handshake, {hi,lo} result, annul and divide-by-zero detect.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_result;
  logic               r_div_zero;

  logic               w_accept;
  logic               w_dz;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [2*WIDTH-1:0] w_final;

  assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_dz     = op_i[1] && (opdata2_i == '0);
  assign w_mag1   = (op_i[0] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_mag2   = (op_i[0] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Multiply: acc = {partial hi, multiplier shifting out of lo}; r_opnd is the multiplicand.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; r_opnd is the divisor.
  assign w_rsh      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rsh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_step  = r_is_div ? w_div_next : w_mul_next;
  assign w_hi    = w_step[2*WIDTH-1:WIDTH];
  assign w_lo    = w_step[WIDTH-1:0];
  assign w_final = r_is_div ? {(r_neg_hi ? -w_hi : w_hi), (r_neg_lo ? -w_lo : w_lo)}
                            : (r_neg_lo ? -w_step : w_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= op_i[1];
            r_opnd   <= op_i[1] ? w_mag2 : w_mag1;
            r_acc    <= {{WIDTH{1'b0}}, (op_i[1] ? w_mag1 : w_mag2)};
            r_neg_lo <= op_i[0] & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_hi <= op_i[0] & opdata1_i[WIDTH-1];
            r_cnt    <= '0;
            if (w_dz) begin
              r_state    <= S_DONE;
              r_div_zero <= 1'b1;
              r_result   <= {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              r_state    <= S_CALC;
              r_div_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_result <= w_final;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (r_state == S_CALC) || (r_state == S_DONE);
  assign ready_o    = (r_state == S_DONE);
  assign result_o   = r_result;
  assign div_zero_o = r_div_zero;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors push expected results,
// negedge monitors pop and compare on every ready_o pulse (WIDTH=32 and WIDTH=8).
module tb_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        start32, annul32, busy32, ready32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic [63:0] result32;

  logic        start8, annul8, busy8, ready8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op32),
    .opdata1_i(a32), .opdata2_i(b32), .annul_i(annul32),
    .busy_o(busy32), .ready_o(ready32), .result_o(result32), .div_zero_o(dz32)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
    .busy_o(busy8), .ready_o(ready8), .result_o(result8), .div_zero_o(dz8)
  );

  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready32) begin
      if (q32.size() == 0) begin
        chk("unexpected_ready32", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk("result32", result32, e.res);
        chk("divzero32", {63'd0, dz32}, {63'd0, e.dz});
        chk("latency32", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready8) begin
      if (q8.size() == 0) begin
        chk("unexpected_ready8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        chk("result8", {48'd0, result8}, e.res);
        chk("divzero8", {63'd0, dz8}, {63'd0, e.dz});
        chk("latency8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1 (accept edge = end of cycle 0).
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic dz, input bit push);
    if (push) q32.push_back('{res, dz, cyc + (dz ? 32'd1 : 32'd33)});
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] res, input logic dz);
    q8.push_back('{{48'd0, res}, dz, cyc + (dz ? 32'd1 : 32'd9)});
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain32(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!busy32 && q32.size() == 0) break;
      @(negedge clk);
    end
    chk(name, {62'd0, busy32, (q32.size() != 0)}, 64'd0);
  endtask

  task automatic drain8(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!busy8 && q8.size() == 0) break;
      @(negedge clk);
    end
    chk(name, {62'd0, busy8, (q8.size() != 0)}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    rst = 1'b1;
    start32 = 1'b0; annul32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; annul8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    #2;
    chk("reset_busy",    {63'd0, busy32}, 64'd0);
    chk("reset_ready",   {63'd0, ready32}, 64'd0);
    chk("reset_result",  result32, 64'd0);
    chk("reset_divzero", {63'd0, dz32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Signed multiply with busy window
    issue32(MULT, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b1);
    nb = 0;
    for (int k = 1; k <= 33; k++) begin
      if (busy32) nb++;
      @(negedge clk);
    end
    chk("busy_cycles_1_33", 64'(nb), 64'd33);
    chk("busy_low_cycle34", {63'd0, busy32}, 64'd0);
    drain32("drain_mult");

    // Unsigned multiply, then back-to-back start in cycle 34
    issue32(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b1);
    repeat (33) @(negedge clk);
    issue32(DIV, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b1);
    drain32("drain_b2b");

    issue32(DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b1);
    drain32("drain_divu");
    issue32(DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b1);
    drain32("drain_div_ovf");
    issue32(MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 1'b1);
    drain32("drain_mult_minneg");
    issue32(DIV, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 1'b1);
    drain32("drain_div_neg");
    issue32(DIVU, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 1'b0, 1'b1);
    drain32("drain_divu_big");

    // Divide by zero completes in cycle 1
    issue32(DIV, 32'h00001234, 32'h0, 64'h00001234_FFFFFFFF, 1'b1, 1'b1);
    drain32("drain_divzero");

    // Annul in cycle 10 of a DIVU
    issue32(DIVU, 32'd1000, 32'd3, 64'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    annul32 = 1'b1;
    @(negedge clk);
    annul32 = 1'b0;
    chk("annul_busy_low", {63'd0, busy32}, 64'd0);
    chk("annul_result_held", result32, 64'h00001234_FFFFFFFF);
    repeat (40) @(negedge clk);

    // start_i during CALC is ignored
    issue32(MULTU, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    start32 = 1'b1; op32 = DIVU; a32 = 32'd77; b32 = 32'd5;
    repeat (10) @(negedge clk);
    start32 = 1'b0;
    drain32("drain_ignored_start");
    repeat (3) @(negedge clk);
    chk("no_queued_start", {63'd0, busy32}, 64'd0);

    // start together with annul in IDLE
    start32 = 1'b1; annul32 = 1'b1; op32 = MULT; a32 = 32'd2; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0; annul32 = 1'b0;
    chk("start_annul_busy", {63'd0, busy32}, 64'd0);
    repeat (2) @(negedge clk);
    chk("start_annul_busy_later", {63'd0, busy32}, 64'd0);
    chk("start_annul_result", result32, 64'h00000000_0000000F);

    // Asynchronous reset mid-CALC, checked before the next rising edge
    issue32(MULT, 32'd7, 32'd9, 64'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy",    {63'd0, busy32}, 64'd0);
    chk("async_rst_ready",   {63'd0, ready32}, 64'd0);
    chk("async_rst_result",  result32, 64'd0);
    chk("async_rst_divzero", {63'd0, dz32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("after_rst_idle", {63'd0, busy32}, 64'd0);

    issue32(DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 1'b1);
    drain32("drain_after_rst");

    // WIDTH=8 instance
    issue8(MULT, 8'h80, 8'h80, 16'h4000, 1'b0);
    drain8("drain8_mult");
    issue8(DIV, 8'h80, 8'hFF, 16'h0080, 1'b0);
    drain8("drain8_div_ovf");
    issue8(DIVU, 8'd200, 8'd0, 16'hC8FF, 1'b1);
    drain8("drain8_divzero");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
